// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit that owns the HI/LO registers (MULT/MULTU/DIV/DIVU, MTHI/MTLO).
// Optional MULDIV_FAST_MULT_EN: single-cycle combinational multiplier for MULT/MULTU.
module muldiv_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned ITER  = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CNT_W = $clog2(ITER);
    localparam int unsigned DW    = 2 * WIDTH;

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               is_div_q, is_div_d;
    logic               neg_q, neg_d;
    logic               rem_neg_q, rem_neg_d;
    logic [WIDTH-1:0]   op_m_q, op_m_d;
    logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    // Operand conditioning at launch
    logic               is_signed;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_abs, b_abs;

    // One serial iteration of each datapath
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH-1:0]   mul_hi_n, mul_lo_n;
    logic [WIDTH:0]     div_sh;
    logic [WIDTH+1:0]   div_diff;
    logic               div_ge;
    logic [WIDTH-1:0]   div_hi_n, div_lo_n;
    logic [WIDTH-1:0]   it_hi, it_lo;

    // Sign-corrected final result
    logic [DW-1:0]      prod_raw, prod_fix;
    logic [WIDTH-1:0]   res_hi, res_lo;

    always_comb begin
        is_signed = ~op[0];
        a_neg     = is_signed & a[WIDTH-1];
        b_neg     = is_signed & b[WIDTH-1];
        a_abs     = a_neg ? WIDTH'(-a) : a;
        b_abs     = b_neg ? WIDTH'(-b) : b;
    end

    // Shift-add multiply: multiplier sits in acc_lo and shifts out as product bits shift in
    always_comb begin
        mul_sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, op_m_q} : '0);
        mul_hi_n = mul_sum[WIDTH:1];
        mul_lo_n = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
    end

    // Restoring divide: dividend shifts out of acc_lo, quotient bits shift in
    always_comb begin
        div_sh   = {acc_hi_q, acc_lo_q[WIDTH-1]};
        div_diff = {1'b0, div_sh} - {2'b00, op_m_q};
        div_ge   = ~div_diff[WIDTH+1];
        div_hi_n = WIDTH'(div_ge ? div_diff[WIDTH:0] : div_sh);
        div_lo_n = {acc_lo_q[WIDTH-2:0], div_ge};
        it_hi    = is_div_q ? div_hi_n : mul_hi_n;
        it_lo    = is_div_q ? div_lo_n : mul_lo_n;
    end

`ifdef MULDIV_FAST_MULT_EN
    logic fast_q, fast_d;

    always_comb begin
        prod_raw = fast_q ? (DW'(op_m_q) * DW'(acc_lo_q)) : {it_hi, it_lo};
    end
`else
    always_comb begin
        prod_raw = {it_hi, it_lo};
    end
`endif

    always_comb begin
        prod_fix = neg_q ? DW'(-prod_raw) : prod_raw;
        if (is_div_q) begin
            res_lo = neg_q ? WIDTH'(-it_lo) : it_lo;
            res_hi = rem_neg_q ? WIDTH'(-it_hi) : it_hi;
        end else begin
            res_lo = prod_fix[WIDTH-1:0];
            res_hi = prod_fix[DW-1:WIDTH];
        end
    end

    // Next-state and register update logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        op_m_d    = op_m_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
`ifdef MULDIV_FAST_MULT_EN
        fast_d    = fast_q;
`endif
        case (state_q)
            IDLE, FINISH: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                if (hi_we) hi_d = wdata;
                if (lo_we) lo_d = wdata;
                if (start) begin
                    state_d   = RUN;
                    busy_d    = 1'b1;
                    is_div_d  = op[1];
                    acc_hi_d  = '0;
                    cnt_d     = CNT_W'(ITER - 1);
                    rem_neg_d = a_neg;
                    if (op[1]) begin
                        op_m_d   = b_abs;
                        acc_lo_d = a_abs;
                        // Divide by zero keeps the all-ones quotient unsigned
                        neg_d    = (a_neg ^ b_neg) & (b != '0);
                    end else begin
                        op_m_d   = a_abs;
                        acc_lo_d = b_abs;
                        neg_d    = a_neg ^ b_neg;
                    end
`ifdef MULDIV_FAST_MULT_EN
                    fast_d = ~op[1];
                    if (!op[1]) cnt_d = '0;
`endif
                end
            end
            RUN: begin
                acc_hi_d = it_hi;
                acc_lo_d = it_lo;
                cnt_d    = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    state_d = FINISH;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    hi_d    = res_hi;
                    lo_d    = res_lo;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            op_m_q    <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef MULDIV_FAST_MULT_EN
            fast_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            op_m_q    <= op_m_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef MULDIV_FAST_MULT_EN
            fast_q    <= fast_d;
`endif
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
